// File: rtl/aes_share_stream_ctrl.sv
// ----------------------------------------------------------------------------
// aes_share_stream_ctrl: 32-bit share stream <-> masked AES core handshake bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_share_stream_ctrl #(
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [128*D-1:0]     core_sh_plaintext,
  output logic [128*D-1:0]     core_sh_key,
  output logic                 core_valid_in,
  input  logic                 core_in_ready,
  input  logic [128*D-1:0]     core_sh_ciphertext,
  input  logic                 core_cipher_valid,
  output logic                 core_out_ready,
  output logic                 busy
);

  localparam int W  = 128 * D;
  localparam int NW = 4 * D;
  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

  localparam logic [2:0] ST_LOAD_PT  = 3'd0;
  localparam logic [2:0] ST_LOAD_KEY = 3'd1;
  localparam logic [2:0] ST_SEND     = 3'd2;
  localparam logic [2:0] ST_WAIT_CT  = 3'd3;
  localparam logic [2:0] ST_UNLOAD   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  pt_reg;
  logic [W-1:0]  key_reg;
  logic [W-1:0]  ct_reg;

  logic          cnt_last;
  logic [CW-1:0] cnt_next;

  assign cnt_last = (cnt == LAST_WORD);
  assign cnt_next = cnt_last ? '0 : cnt + CW'(1);

  // Shares are cleared on every handoff so nothing sensitive lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_LOAD_PT;
      cnt     <= '0;
      pt_reg  <= '0;
      key_reg <= '0;
      ct_reg  <= '0;
    end else begin
      case (state)
        ST_LOAD_PT: begin
          if (s_valid) begin
            pt_reg[{cnt, 5'd0} +: 32] <= s_data;
            cnt <= cnt_next;
            if (cnt_last) state <= ST_LOAD_KEY;
          end
        end
        ST_LOAD_KEY: begin
          if (s_valid) begin
            key_reg[{cnt, 5'd0} +: 32] <= s_data;
            cnt <= cnt_next;
            if (cnt_last) state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (core_in_ready) begin
            pt_reg  <= '0;
            key_reg <= '0;
            state   <= ST_WAIT_CT;
          end
        end
        ST_WAIT_CT: begin
          if (core_cipher_valid) begin
            ct_reg <= core_sh_ciphertext;
            state  <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            cnt <= cnt_next;
            if (cnt_last) begin
              ct_reg <= '0;
              state  <= ST_LOAD_PT;
            end
          end
        end
        default: begin
          state <= ST_LOAD_PT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Every output is a decode of registered state, never of an input.
  assign s_ready           = (state == ST_LOAD_PT) || (state == ST_LOAD_KEY);
  assign core_valid_in     = (state == ST_SEND);
  assign core_out_ready    = (state == ST_WAIT_CT);
  assign m_valid           = (state == ST_UNLOAD);
  assign core_sh_plaintext = core_valid_in ? pt_reg  : '0;
  assign core_sh_key       = core_valid_in ? key_reg : '0;
  assign m_data            = m_valid ? ct_reg[{cnt, 5'd0} +: 32] : 32'd0;
  assign busy              = !((state == ST_LOAD_PT) && (cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_aes_share_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_share_stream_ctrl: scoreboard bench with a behavioural masked-core model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_aes_share_stream_ctrl;

  localparam int D  = 2;
  localparam int W  = 128 * D;
  localparam int NW = 4 * D;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  core_sh_plaintext;
  logic [W-1:0]  core_sh_key;
  logic          core_valid_in;
  logic          core_in_ready;
  logic [W-1:0]  core_sh_ciphertext;
  logic          core_cipher_valid;
  logic          core_out_ready;
  logic          busy;

  logic          model_cv;
  logic          spur_cv;
  assign core_cipher_valid = model_cv | spur_cv;

  aes_share_stream_ctrl #(.D(D)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_sh_plaintext(core_sh_plaintext), .core_sh_key(core_sh_key),
    .core_valid_in(core_valid_in), .core_in_ready(core_in_ready),
    .core_sh_ciphertext(core_sh_ciphertext), .core_cipher_valid(core_cipher_valid),
    .core_out_ready(core_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int stall_req = 0;
  int zero_viol = 0;
  bit use_rnd_ct = 1'b0;
  logic [31:0]  exp_word_q[$];
  logic [127:0] ct_q[$];

  function automatic logic [W-1:0] share(input logic [127:0] v, input logic [127:0] m);
    logic [W-1:0] s = '0;
    for (int i = 0; i < 128; i++) begin
      s[i*D]   = v[i] ^ m[i];
      s[i*D+1] = m[i];
    end
    return s;
  endfunction

  function automatic logic [127:0] recomb(input logic [W-1:0] s);
    logic [127:0] v = '0;
    for (int i = 0; i < 128; i++) v[i] = s[i*D] ^ s[i*D+1];
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Plaintext/key shares must read zero whenever the core is not being offered data.
  always @(negedge clk)
    if (!rst && !core_valid_in && (core_sh_plaintext !== '0 || core_sh_key !== '0))
      zero_viol <= zero_viol + 1;

  // Behavioural core: recombines, "encrypts" (FIPS vector known, else pt^key), re-masks.
  initial begin : core_model
    int cst, scnt, lat;
    bit fire_out;
    logic [127:0] pt, key, ct, msk;
    logic [W-1:0] sh;
    cst = 0; scnt = 0; lat = 0; sh = '0;
    core_in_ready = 1'b0; model_cv = 1'b0; core_sh_ciphertext = '0;
    forever begin
      @(negedge clk);
      fire_out = model_cv && core_out_ready;
      @(posedge clk); #1;
      if (rst) begin
        cst = 0; scnt = 0;
        core_in_ready = 1'b0; model_cv = 1'b0; core_sh_ciphertext = '0;
      end else begin
        case (cst)
          0: if (core_valid_in) begin
               if (scnt >= stall_req) begin
                 core_in_ready = 1'b1; cst = 1; scnt = 0;
                 pt  = recomb(core_sh_plaintext);
                 key = recomb(core_sh_key);
                 ct  = (pt == FIPS_PT && key == FIPS_KEY) ? FIPS_CT : (pt ^ key);
                 msk = use_rnd_ct ? rand128() : 128'd0;
                 sh  = share(ct, msk);
                 for (int k = 0; k < NW; k++) exp_word_q.push_back(sh[32*k +: 32]);
               end else begin
                 scnt++;
               end
             end
          1: begin core_in_ready = 1'b0; lat = 0; cst = 2; end
          2: begin
               lat++;
               if (lat == 3) begin model_cv = 1'b1; core_sh_ciphertext = sh; cst = 3; end
             end
          default: if (fire_out) begin
               model_cv = 1'b0;
               core_sh_ciphertext = {rand128(), rand128()};
               cst = 0;
             end
        endcase
      end
    end
  end

  task automatic send_word(input logic [31:0] w, output int acc);
    int t = 0;
    s_valid = 1'b1; s_data = w;
    @(negedge clk);
    while (s_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (s_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL s_ready_wait: got=%b exp=1", s_ready);
    end
    acc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '0;
  endtask

  task automatic load_vec(input logic [W-1:0] v, input bit gap, output int first_acc);
    int a;
    first_acc = 0;
    for (int k = 0; k < NW; k++) begin
      send_word(v[32*k +: 32], a);
      if (k == 0) first_acc = a;
      if (gap && k != NW-1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_phase(input logic [W-1:0] pe, input logic [W-1:0] ke,
                            input int first_acc, input bit chk_lat);
    int t = 0;
    int sc = 0;
    @(negedge clk);
    if (chk_lat) begin
      total++;
      if (cyc - first_acc != 16) begin
        bad++; $display("FAIL valid_in_latency: got=%0d exp=16", cyc - first_acc);
      end
    end
    while (t < 200) begin
      total++;
      if (core_valid_in !== 1'b1 || core_sh_plaintext !== pe || core_sh_key !== ke) begin
        bad++;
        $display("FAIL send_hold: valid=%b pt=%h exp_pt=%h", core_valid_in, core_sh_plaintext, pe);
        break;
      end
      sc++;
      if (core_in_ready === 1'b1) break;
      @(negedge clk); t++;
    end
    @(posedge clk); #1;
    total++;
    if (dut.pt_reg !== '0 || dut.key_reg !== '0 || core_valid_in !== 1'b0 || core_out_ready !== 1'b1) begin
      bad++;
      $display("FAIL regs_cleared: pt_reg=%h key_reg=%h valid_in=%b out_ready=%b exp 0/0/0/1",
               dut.pt_reg, dut.key_reg, core_valid_in, core_out_ready);
    end
    total++;
    if (sc != stall_req + 1) begin
      bad++; $display("FAIL send_cycles: got=%0d exp=%0d", sc, stall_req + 1);
    end
  endtask

  task automatic unload_phase(input int stall_at, input int stall_len, input bit spur_s,
                              output logic [W-1:0] got);
    int t = 0;
    logic [31:0] e;
    logic [127:0] ect;
    got = '0;
    if (spur_s) begin s_valid = 1'b1; s_data = 32'hdeadbeef; end
    @(negedge clk);
    while (m_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    total++;
    if (m_valid !== 1'b1) begin
      bad++; $display("FAIL unload_wait: m_valid=%b exp=1", m_valid);
      s_valid = 1'b0; s_data = '0;
      return;
    end
    @(posedge clk); #1;
    for (int k = 0; k < NW; k++) begin
      e = '0;
      if (exp_word_q.size() == 0) begin
        total++; bad++; $display("FAIL scoreboard_empty: word=%0d got=0 exp=%0d", k, NW - k);
      end else begin
        e = exp_word_q.pop_front();
      end
      if (k == stall_at) begin
        m_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          total++;
          if (m_valid !== 1'b1 || m_data !== e) begin
            bad++; $display("FAIL stall_hold: m_valid=%b m_data=%h exp=%h", m_valid, m_data, e);
          end
          @(posedge clk); #1;
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || m_data !== e) begin
        bad++; $display("FAIL m_data[%0d]: got=%h valid=%b exp=%h", k, m_data, m_valid, e);
      end
      if (spur_s) begin
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL s_ready_unload: got=%b exp=0", s_ready); end
      end
      got[32*k +: 32] = m_data;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
    s_valid = 1'b0; s_data = '0;
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || m_data !== 32'd0 || dut.cnt !== '0) begin
      bad++;
      $display("FAIL after_unload: s_ready=%b busy=%b m_valid=%b m_data=%h exp 1/0/0/0",
               s_ready, busy, m_valid, m_data);
    end
    if (spur_s) begin
      total++;
      if (dut.pt_reg !== '0) begin bad++; $display("FAIL spur_s_ignored: pt_reg=%h exp=0", dut.pt_reg); end
    end
    ect = (ct_q.size() != 0) ? ct_q.pop_front() : 128'd0;
    total++;
    if (recomb(got) !== ect) begin
      bad++; $display("FAIL ciphertext: got=%h exp=%h", recomb(got), ect);
    end
  endtask

  task automatic encrypt(input bit rnd, input bit gap, input int stall_at, input int stall_len,
                         output logic [W-1:0] got);
    logic [W-1:0] ps, ks;
    int fa, fk;
    use_rnd_ct = rnd;
    ps = share(FIPS_PT,  rnd ? rand128() : 128'd0);
    ks = share(FIPS_KEY, rnd ? rand128() : 128'd0);
    ct_q.push_back(FIPS_CT);
    load_vec(ps, gap, fa);
    load_vec(ks, gap, fk);
    send_phase(ps, ks, fa, !gap);
    unload_phase(stall_at, stall_len, 1'b0, got);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; spur_cv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got=%b exp=1", s_ready); end
    total++;
    if (m_valid !== 1'b0 || m_data !== 32'd0) begin
      bad++; $display("FAIL reset_m: m_valid=%b m_data=%h exp 0/0", m_valid, m_data);
    end
    total++;
    if (core_valid_in !== 1'b0 || core_out_ready !== 1'b0 || core_sh_plaintext !== '0 || core_sh_key !== '0) begin
      bad++; $display("FAIL reset_core: valid_in=%b out_ready=%b exp 0/0 and zero data", core_valid_in, core_out_ready);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    logic [W-1:0] g;
    encrypt(1'b0, 1'b0, -1, 0, g);
    total++;
    if (g !== share(FIPS_CT, 128'd0)) begin
      bad++; $display("FAIL fips_shares: got=%h exp=%h", g, share(FIPS_CT, 128'd0));
    end
  endtask

  task automatic test_random_mask();
    logic [W-1:0] g1, g2;
    encrypt(1'b1, 1'b0, -1, 0, g1);
    encrypt(1'b1, 1'b0, -1, 0, g2);
    total++;
    if (g1 === g2) begin bad++; $display("FAIL shares_differ: got=%h exp=different", g2); end
    total++;
    if (zero_viol != 0) begin bad++; $display("FAIL core_sh_gating: got=%0d exp=0", zero_viol); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] g;
    encrypt(1'b1, 1'b1, 3, 10, g);
  endtask

  task automatic test_core_stall();
    logic [W-1:0] g;
    stall_req = 20;
    encrypt(1'b1, 1'b0, -1, 0, g);
    stall_req = 0;
  endtask

  task automatic test_reset_mid_load();
    logic [W-1:0] ps, g;
    int a;
    ps = share(FIPS_PT, rand128());
    for (int k = 0; k < 5; k++) send_word(ps[32*k +: 32], a);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_loading: got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || core_valid_in !== 1'b0 ||
        dut.cnt !== '0 || dut.pt_reg !== '0) begin
      bad++; $display("FAIL async_reset: s_ready=%b busy=%b cnt=%0d exp 1/0/0", s_ready, busy, dut.cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    encrypt(1'b0, 1'b0, -1, 0, g);
  endtask

  task automatic test_spurious();
    logic [W-1:0] ps, ks, g;
    int fa, a;
    use_rnd_ct = 1'b1;
    ps = share(FIPS_PT,  rand128());
    ks = share(FIPS_KEY, rand128());
    ct_q.push_back(FIPS_CT);
    load_vec(ps, 1'b0, fa);
    for (int k = 0; k < 3; k++) send_word(ks[32*k +: 32], a);
    spur_cv = 1'b1;
    @(negedge clk);
    total++;
    if (core_out_ready !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL spur_cv_levels: out_ready=%b s_ready=%b exp 0/1", core_out_ready, s_ready);
    end
    @(posedge clk); #1;
    spur_cv = 1'b0;
    total++;
    if (dut.cnt !== 3'd3 || m_valid !== 1'b0 || core_valid_in !== 1'b0) begin
      bad++; $display("FAIL spur_cv_ignored: cnt=%0d m_valid=%b exp 3/0", dut.cnt, m_valid);
    end
    for (int k = 3; k < NW; k++) send_word(ks[32*k +: 32], a);
    send_phase(ps, ks, 0, 1'b0);
    unload_phase(-1, 0, 1'b1, g);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] g;
    encrypt(1'b0, 1'b0, -1, 0, g);
    encrypt(1'b1, 1'b0, 5, 2, g);
  endtask

  initial begin
    test_reset();
    test_fips();
    test_random_mask();
    test_backpressure();
    test_core_stall();
    test_reset_mid_load();
    test_spurious();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/aes_share_stream_ctrl.md
# aes_share_stream_ctrl

Stream-side driver for the masked 32-bit AES encryption core, sitting between a 32-bit share bus and the core's wide handshake interface. It deserializes the plaintext and key sharings from 32-bit words, presents them with `valid_in`/`in_ready`, collects the masked ciphertext with `cipher_valid`/`out_ready`, and serializes it back out as 32-bit words. It holds sensitive shares only as long as needed and zeroes its registers after each handoff.

## Interface
- `d`, 2, masking order (number of shares); the sharing is bit-compact: bit i, share j at index i*d+j.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_data` in 32: input share word.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: block accepts a word.
- `m_data` out 32: output ciphertext share word.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: downstream accepts a word.
- `core_sh_plaintext` out 128*d: to core `sh_plaintext`.
- `core_sh_key` out 128*d: to core `sh_key`.
- `core_valid_in` out 1: to core `valid_in`.
- `core_in_ready` in 1: from core `in_ready`.
- `core_sh_ciphertext` in 128*d: from core `sh_ciphertext`.
- `core_cipher_valid` in 1: from core `cipher_valid`.
- `core_out_ready` out 1: to core `out_ready`.
- `busy` out 1: high whenever not idle in LOAD_PT with word counter 0.

## Operation
- Registers: `pt_reg`, `key_reg`, `ct_reg` (128*d each); word counter `cnt`, range 0..4d-1; FSM states LOAD_PT, LOAD_KEY, SEND, WAIT_CT, UNLOAD.
- Word k of a 128*d vector is bits [32k +: 32], k = 0..4d-1, in ascending k order on both streams.
- LOAD_PT: `s_ready`=1. On `s_valid`&`s_ready`: `pt_reg` word `cnt` <= `s_data`, and `cnt` increments. At `cnt`=4d-1, `cnt` wraps to 0 and the FSM moves to LOAD_KEY.
- LOAD_KEY: same behaviour into `key_reg`; on the last word the FSM moves to SEND.
- SEND: `core_valid_in`=1, `core_sh_plaintext`=`pt_reg`, `core_sh_key`=`key_reg`. On `core_in_ready`, the next edge sets the FSM to WAIT_CT and zeroes `pt_reg` and `key_reg`.
- Outside SEND, `core_sh_plaintext` and `core_sh_key` are forced to all-zero. Only the combinational gating is forced; the register contents are untouched.
- WAIT_CT: `core_out_ready`=1. On `core_cipher_valid`, `ct_reg` <= `core_sh_ciphertext` and the FSM moves to UNLOAD. The core drops the ciphertext in that same cycle because both handshake signals are high.
- UNLOAD: `m_valid`=1, `m_data`=`ct_reg` word `cnt`. On `m_ready`, `cnt` increments. On the last word, `cnt` returns to 0, `ct_reg` is zeroed and the FSM returns to LOAD_PT.
- `m_data` is 0 whenever `m_valid`=0.
- `core_cipher_valid` outside WAIT_CT is ignored; `core_out_ready` stays 0 there.
- `s_valid` outside the LOAD states is ignored, with `s_ready`=0.
- The block never inspects or combines shares.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = LOAD_PT, `cnt`=0, all registers = 0;
  - outputs `s_ready`=1, `m_valid`=0, `m_data`=0, `core_valid_in`=0, `core_out_ready`=0, core data outputs = 0, `busy`=0.
- Reset mid-operation, in any state, discards all shares and restarts at LOAD_PT. The core is reset separately.
- All outputs are decoded from registered state/`cnt` only, with no input-to-output combinational path. The one exception is that the `core_out_ready` and `core_valid_in` levels are state-only, so they are also compliant.
- Load phase: at least 8d cycles (one word per cycle with `s_valid` held high).
- SEND lasts at least 1 cycle. `core_valid_in` is held until `core_in_ready`, and data is stable throughout.
- Unload phase: at least 4d cycles. `m_data`/`m_valid` are held stable while `m_ready`=0.
- Back-to-back: LOAD_PT accepts a word the cycle after the last UNLOAD transfer.
- Throughput is bounded by the core latency; only one encryption is in flight.

## Test plan
- **FIPS-197 vector, d=2, share1=0.**
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, streamed as 16 words.
  - Required response: recombined output equals 69c4e0d86a7b0430d8cdb78070b4c55a. `core_valid_in` rises exactly 16 cycles after the first accepted word.
- **Same vector, random mask shares.**
  - Required response: the output shares differ from run to run, but XOR-recombine to the same ciphertext. `core_sh_*` reads all-zero in every non-SEND cycle.
- **Backpressure.**
  - Stimulus: `s_valid` toggled every other cycle; `m_ready` low for 10 cycles mid-unload.
  - Required response: no word is lost or duplicated; `m_data` is stable during the stall; the result is correct.
- **Core stall.**
  - Stimulus: `core_in_ready` held low for 20 cycles.
  - Required response: `core_valid_in` and the data are held constant. After acceptance, `pt_reg`/`key_reg` read zero one cycle later.
- **Reset mid-load.**
  - Stimulus: assert `rst` after 5 words.
  - Required response: the outputs immediately take their reset values. A subsequent full 16-word load produces the correct ciphertext.
- **Spurious inputs.**
  - Stimulus: `core_cipher_valid` pulsed during LOAD_KEY; `s_valid` held high during UNLOAD.
  - Required response: both are ignored; the state and counters are unchanged; `s_ready`=0 in UNLOAD.
